uart_rx_deserializer: RTL and testbench

- UART receive front end: synchronises the serial input, detects and validates start bits, and samples each bit mid-cell at 16x oversampling.
- Assembles data, parity and stop bits into an 11-bit receive record and pushes it into the receive FIFO.
- Record layout matches the FIFO: bits [10:3] = data byte, bits [2:0] = flags.
- Sits between the pad/baud generator and the receive FIFO.

---
 rtl/uart_rx_deserializer.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises the serial line, validates the start bit,
// samples data/parity/stop mid-cell and pushes one 11-bit record per frame.
module uart_rx_deserializer #(
  parameter int REC_WIDTH  = 11,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 srx_pad_i,
  input  logic [1:0]           char_len,
  input  logic                 parity_en,
  input  logic                 parity_even,
  input  logic                 stick_parity,
  output logic [REC_WIDTH-1:0] rf_data_in,
  output logic                 rf_push,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    PUSH      = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_acc;
  logic          all_zero;
  logic          par_err;
  logic [1:0]    cfg_len;
  logic          cfg_par_en;
  logic          cfg_even;
  logic          cfg_stick;

  // Expected parity bit for the latched frame configuration.
  function automatic logic exp_parity(input logic acc, input logic even, input logic stick);
    exp_parity = stick ? ~even : (acc ^ ~even);
  endfunction

  // Two-flop synchroniser on the asynchronous pad input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= srx_pad_i;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM with registered record, push strobe and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_acc    <= 1'b0;
      all_zero   <= 1'b0;
      par_err    <= 1'b0;
      cfg_len    <= 2'd0;
      cfg_par_en <= 1'b0;
      cfg_even   <= 1'b0;
      cfg_stick  <= 1'b0;
      rf_data_in <= '0;
      rf_push    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rf_push <= 1'b0;
      case (state)
        IDLE: begin
          if (baud_tick && !rxs) begin
            state    <= START;
            tick_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              if (rxs) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                cfg_len    <= char_len;
                cfg_par_en <= parity_en;
                cfg_even   <= parity_even;
                cfg_stick  <= stick_parity;
                shreg      <= 8'h00;
                bit_cnt    <= 3'd0;
                par_acc    <= 1'b0;
                all_zero   <= 1'b1;
                par_err    <= 1'b0;
                state      <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt       <= '0;
              shreg[bit_cnt] <= rxs;
              par_acc        <= par_acc ^ rxs;
              all_zero       <= all_zero & ~rxs;
              if (bit_cnt == (3'd4 + {1'b0, cfg_len})) begin
                state <= cfg_par_en ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              par_err  <= (rxs != exp_parity(par_acc, cfg_even, cfg_stick));
              all_zero <= all_zero & ~rxs;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              rf_push  <= 1'b1;
              state    <= PUSH;
              // An all-zero frame is a break: data and parity are meaningless.
              if (all_zero && !rxs) begin
                rf_data_in <= REC_WIDTH'(3'b101);
              end else begin
                rf_data_in <= REC_WIDTH'({shreg, 1'b0, par_err, ~rxs});
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PUSH: begin
          if (rxs) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (baud_tick && rxs) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: expected records are queued as
// frames are driven and compared when the DUT pulses rf_push.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud_tick;
  logic        srx_pad_i;
  logic [1:0]  char_len;
  logic        parity_en;
  logic        parity_even;
  logic        stick_parity;
  logic [10:0] rf_data_in;
  logic        rf_push;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  uart_rx_deserializer #(.REC_WIDTH(11), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .srx_pad_i    (srx_pad_i),
    .char_len     (char_len),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .stick_parity (stick_parity),
    .rf_data_in   (rf_data_in),
    .rf_push      (rf_push),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // baud_tick one clk in four.
  initial begin
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      baud_tick = (cnt == 3);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every push is compared against the oldest queued record.
  always @(negedge clk) begin
    if (rf_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_push", {21'd0, rf_data_in}, 32'hFFFF_FFFF);
      end else begin
        check_eq("record", {21'd0, rf_data_in}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic b);
    srx_pad_i = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic pen, input logic even, input logic stick);
    char_len = len; parity_en = pen; parity_even = even; stick_parity = stick;
  endtask

  task automatic idle_bits(input int n);
    srx_pad_i = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    srx_pad_i = 1'b1;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("reset_data", {21'd0, rf_data_in}, 32'd0);
    check_eq("reset_push", {31'd0, rf_push}, 32'd0);
    check_eq("reset_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // 8N1 0xA5
    exp_q.push_back({8'hA5, 3'b000});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check_eq("busy_after_8n1", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);

    // 7E1 0x41: correct parity bit is 0
    set_cfg(2'd2, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({8'h41, 3'b010});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({8'h41, 3'b000});
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    idle_bits(1);

    // 5-bit stick parity, expected parity bit 1
    set_cfg(2'd0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({8'h1F, 3'b000});
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({8'h1F, 3'b010});
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    idle_bits(1);

    // 8N1 0x3C with a low stop bit; line stays low afterwards
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({8'h3C, 3'b001});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check_eq("wait_idle_busy", {31'd0, rx_busy}, 32'd1);
    idle_bits(1);
    check_eq("wait_idle_exit", {31'd0, rx_busy}, 32'd0);

    // Break: line low for two frame times, then a clean 0x55
    exp_q.push_back(11'b00000000_101);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    check_eq("break_busy", {31'd0, rx_busy}, 32'd1);
    idle_bits(2);
    exp_q.push_back({8'h55, 3'b000});
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);

    // Glitch: 5-tick low pulse
    srx_pad_i = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(1);
    check_eq("glitch_busy", {31'd0, rx_busy}, 32'd0);
    check_eq("glitch_data_held", {21'd0, rf_data_in}, {21'd0, 8'h55, 3'b000});

    // Reset during data bit 4, then a clean 0x81
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    srx_pad_i = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check_eq("busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_data", {21'd0, rf_data_in}, 32'd0);
    check_eq("rst_mid_push", {31'd0, rf_push}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    idle_bits(12);
    check_eq("rst_no_push", {21'd0, rf_data_in}, 32'd0);
    exp_q.push_back({8'h81, 3'b000});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
